// File: rtl/proc_controller_if.sv
// Handshake and control bundle between the instruction source and proc_controller.
// The master drives EXEC/INSTR; the slave (the controller) drives all strobes.
interface proc_controller_if #(
    parameter int IR_W = 10
);
    logic            EXEC;
    logic [IR_W-1:0] INSTR;
    logic [1:0]      TIME;
    logic            DONE;
    logic            EXTRN;
    logic            RD_OE;
    logic [1:0]      RD_ADDR;
    logic            WR_EN;
    logic [1:0]      WR_ADDR;
    logic            A_IN;
    logic            G_IN;
    logic            G_OUT;
    logic            ALU_SUB;

    modport master (
        output EXEC, INSTR,
        input  TIME, DONE, EXTRN, RD_OE, RD_ADDR, WR_EN, WR_ADDR,
               A_IN, G_IN, G_OUT, ALU_SUB
    );

    modport slave (
        input  EXEC, INSTR,
        output TIME, DONE, EXTRN, RD_OE, RD_ADDR, WR_EN, WR_ADDR,
               A_IN, G_IN, G_OUT, ALU_SUB
    );
endinterface

// File: rtl/proc_controller.sv
// Instruction sequencer for the 10-bit bus processor: latches an instruction on an
// EXEC rising edge and steps T0..T3, decoding bus/regfile/ALU strobes from step and IR.
module proc_controller #(
    parameter int IR_W = 10
) (
    input logic             CLK,
    input logic             RST,
    proc_controller_if.slave bus
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

    step_e           step_q, step_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            exec_q, exec_d;

    logic [1:0] op, rx, ry;
    logic       done;
    logic       unused_ir;

    assign op        = ir_q[IR_W-1 -: 2];
    assign rx        = ir_q[IR_W-3 -: 2];
    assign ry        = ir_q[IR_W-5 -: 2];
    assign unused_ir = ^ir_q[IR_W-7:0];

    // LOAD/MOV finish in T1, ADD/SUB in T3
    assign done = (!op[1] && step_q == T1) || (op[1] && step_q == T3);

    always_ff @(posedge CLK) begin
        if (RST) begin
            step_q <= T0;
            ir_q   <= '0;
            exec_q <= 1'b1;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            exec_q <= exec_d;
        end
    end

    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        exec_d = bus.EXEC;
        if (step_q == T0) begin
            if (bus.EXEC && !exec_q) begin
                step_d = T1;
                ir_d   = bus.INSTR;
            end
        end else if (done) begin
            step_d = T0;
        end else begin
            step_d = step_e'(step_q + 2'd1);
        end
    end

    always_comb begin
        bus.TIME    = step_q;
        bus.DONE    = done;
        bus.EXTRN   = 1'b0;
        bus.RD_OE   = 1'b0;
        bus.RD_ADDR = rx;
        bus.WR_EN   = 1'b0;
        bus.WR_ADDR = rx;
        bus.A_IN    = 1'b0;
        bus.G_IN    = 1'b0;
        bus.G_OUT   = 1'b0;
        bus.ALU_SUB = 1'b0;
        case (step_q)
            T1: begin
                if (op == 2'b00) begin
                    bus.EXTRN = 1'b1;
                    bus.WR_EN = 1'b1;
                end else if (op == 2'b01) begin
                    bus.RD_ADDR = ry;
                    bus.RD_OE   = 1'b1;
                    bus.WR_EN   = 1'b1;
                end else begin
                    bus.RD_OE = 1'b1;
                    bus.A_IN  = 1'b1;
                end
            end
            T2: begin
                if (op[1]) begin
                    bus.RD_ADDR = ry;
                    bus.RD_OE   = 1'b1;
                    bus.G_IN    = 1'b1;
                    bus.ALU_SUB = op[0];
                end
            end
            T3: begin
                if (op[1]) begin
                    bus.G_OUT = 1'b1;
                    bus.WR_EN = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_proc_controller.sv
// Directed and random-stream checks for proc_controller; outputs sampled on the falling edge.
module tb_proc_controller;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    proc_controller_if #(.IR_W(10)) bus ();

    proc_controller #(.IR_W(10)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // {TIME, DONE, EXTRN, RD_OE, RD_ADDR, WR_EN, WR_ADDR, A_IN, G_IN, G_OUT, ALU_SUB}
    logic [13:0] obs;
    assign obs = {bus.TIME, bus.DONE, bus.EXTRN, bus.RD_OE, bus.RD_ADDR, bus.WR_EN,
                  bus.WR_ADDR, bus.A_IN, bus.G_IN, bus.G_OUT, bus.ALU_SUB};

    // Returns {care_mask, expected}; rd < 0 leaves RD_ADDR unchecked, WR_ADDR only checked when we=1.
    function automatic logic [27:0] ev(input int tm, input int dn, input int ex, input int oe,
                                       input int rd, input int we, input int wa, input int ai,
                                       input int gi, input int go, input int sb);
        logic [13:0] v, m;
        m = '1;
        v = '0;
        v[13:12] = tm[1:0];
        v[11] = dn[0];
        v[10] = ex[0];
        v[9]  = oe[0];
        if (rd < 0) m[8:7] = 2'b00; else v[8:7] = rd[1:0];
        v[6] = we[0];
        if (we == 0) m[5:4] = 2'b00; else v[5:4] = wa[1:0];
        v[3] = ai[0];
        v[2] = gi[0];
        v[1] = go[0];
        v[0] = sb[0];
        return {m, v};
    endfunction

    task automatic test_reset();
        logic [27:0] e;
        bus.EXEC  = 1'b0;
        bus.INSTR = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        e = ev(0,0,0,0,0,0,0,0,0,0,0);
        n_cmp++;
        if ((obs & e[27:14]) !== e[13:0]) begin
            n_fail++;
            $display("FAIL reset_held: got %b want %b mask %b", obs, e[13:0], e[27:14]);
        end
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ((obs & e[27:14]) !== e[13:0]) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b mask %b", obs, e[13:0], e[27:14]);
        end
    endtask

    task automatic test_load();
        logic [27:0] x[2];
        x[0] = ev(1,1,1,0,-1,1,2,0,0,0,0);
        x[1] = ev(0,0,0,0, 2,0,0,0,0,0,0);
        bus.EXEC = 1'b0;
        @(negedge CLK);
        bus.INSTR = 10'b00_10_000000;
        bus.EXEC  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            bus.EXEC = 1'b0;
            n_cmp++;
            if ((obs & x[i][27:14]) !== x[i][13:0]) begin
                n_fail++;
                $display("FAIL load_c%0d: got %b want %b mask %b", i, obs, x[i][13:0], x[i][27:14]);
            end
        end
    endtask

    task automatic test_add_sub();
        logic [9:0]  ins[2];
        logic [27:0] x[2][4];
        ins[0] = 10'b10_01_11_0000;
        x[0][0] = ev(1,0,0,1, 1,0,0,1,0,0,0);
        x[0][1] = ev(2,0,0,1, 3,0,0,0,1,0,0);
        x[0][2] = ev(3,1,0,0,-1,1,1,0,0,1,0);
        x[0][3] = ev(0,0,0,0, 1,0,0,0,0,0,0);
        ins[1] = 10'b11_00_01_0000;
        x[1][0] = ev(1,0,0,1, 0,0,0,1,0,0,0);
        x[1][1] = ev(2,0,0,1, 1,0,0,0,1,0,1);
        x[1][2] = ev(3,1,0,0,-1,1,0,0,0,1,0);
        x[1][3] = ev(0,0,0,0, 0,0,0,0,0,0,0);
        for (int k = 0; k < 2; k++) begin
            bus.EXEC = 1'b0;
            @(negedge CLK);
            bus.INSTR = ins[k];
            bus.EXEC  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK);
                bus.EXEC = 1'b0;
                n_cmp++;
                if ((obs & x[k][i][27:14]) !== x[k][i][13:0]) begin
                    n_fail++;
                    $display("FAIL %s_c%0d: got %b want %b mask %b", (k == 0) ? "add" : "sub",
                             i, obs, x[k][i][13:0], x[k][i][27:14]);
                end
            end
        end
    endtask

    task automatic test_mov();
        logic [27:0] x[2];
        x[0] = ev(1,1,0,1, 1,1,0,0,0,0,0);
        x[1] = ev(0,0,0,0, 0,0,0,0,0,0,0);
        bus.EXEC = 1'b0;
        @(negedge CLK);
        bus.INSTR = 10'b01_00_01_0000;
        bus.EXEC  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            bus.EXEC = 1'b0;
            n_cmp++;
            if ((obs & x[i][27:14]) !== x[i][13:0]) begin
                n_fail++;
                $display("FAIL mov_c%0d: got %b want %b mask %b", i, obs, x[i][13:0], x[i][27:14]);
            end
        end
    endtask

    task automatic test_held_exec();
        int dones = 0;
        int busy  = 0;
        bus.EXEC = 1'b0;
        @(negedge CLK);
        bus.INSTR = 10'b10_01_11_0000;
        bus.EXEC  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) dones++;
            if (bus.TIME !== 2'd0) busy++;
        end
        bus.EXEC = 1'b0;
        n_cmp++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL held_done_count: got %0d want 1", dones);
        end
        n_cmp++;
        if (busy !== 3) begin
            n_fail++;
            $display("FAIL held_busy_cycles: got %0d want 3", busy);
        end
    endtask

    task automatic test_ignore_edge();
        logic [27:0] x[5];
        x[0] = ev(1,0,0,1, 1,0,0,1,0,0,0);
        x[1] = ev(2,0,0,1, 3,0,0,0,1,0,0);
        x[2] = ev(3,1,0,0,-1,1,1,0,0,1,0);
        x[3] = ev(0,0,0,0, 1,0,0,0,0,0,0);
        x[4] = ev(0,0,0,0, 1,0,0,0,0,0,0);
        bus.EXEC = 1'b0;
        @(negedge CLK);
        bus.INSTR = 10'b10_01_11_0000;
        bus.EXEC  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            // drop EXEC in T1, re-raise it in T2 and scramble INSTR throughout
            bus.EXEC  = (i >= 1);
            bus.INSTR = (i == 0) ? 10'b00_11_000000 : 10'b01_10_00_1111;
            n_cmp++;
            if ((obs & x[i][27:14]) !== x[i][13:0]) begin
                n_fail++;
                $display("FAIL ignore_c%0d: got %b want %b mask %b", i, obs, x[i][13:0], x[i][27:14]);
            end
        end
        bus.EXEC = 1'b0;
    endtask

    task automatic test_reset_held_exec();
        logic [27:0] x[6];
        for (int i = 0; i < 4; i++) x[i] = ev(0,0,0,0,0,0,0,0,0,0,0);
        x[4] = ev(1,1,1,0,-1,1,3,0,0,0,0);
        x[5] = ev(0,0,0,0, 3,0,0,0,0,0,0);
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'b00_11_000000;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bus.EXEC = (i == 2) ? 1'b0 : (i == 3) ? 1'b1 : (i >= 4) ? 1'b0 : 1'b1;
            n_cmp++;
            if ((obs & x[i][27:14]) !== x[i][13:0]) begin
                n_fail++;
                $display("FAIL rst_exec_c%0d: got %b want %b mask %b", i, obs, x[i][13:0], x[i][27:14]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] x[5];
        x[0] = ev(2,0,0,1,3,0,0,0,1,0,0);
        for (int i = 1; i < 5; i++) x[i] = ev(0,0,0,0,0,0,0,0,0,0,0);
        bus.EXEC = 1'b0;
        @(negedge CLK);
        bus.INSTR = 10'b10_01_11_0000;
        bus.EXEC  = 1'b1;
        @(negedge CLK);
        bus.EXEC = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            RST = (i == 0);
            n_cmp++;
            if ((obs & x[i][27:14]) !== x[i][13:0]) begin
                n_fail++;
                $display("FAIL rst_mid_c%0d: got %b want %b mask %b", i, obs, x[i][13:0], x[i][27:14]);
            end
        end
    endtask

    task automatic test_random_stream();
        int         mstep = 0;
        logic [1:0] mop = 2'b00;
        logic       mprev;
        int         starts = 0;
        int         dones  = 0;
        bus.EXEC = 1'b0;
        @(negedge CLK);
        mprev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ($countones({bus.EXTRN, bus.RD_OE, bus.G_OUT}) > 1) begin
                n_fail++;
                $display("FAIL bus_exclusive cyc%0d: got EXTRN/RD_OE/G_OUT=%b want at most one", i,
                         {bus.EXTRN, bus.RD_OE, bus.G_OUT});
            end
            n_cmp++;
            if (bus.TIME !== 2'(mstep)) begin
                n_fail++;
                $display("FAIL rand_time cyc%0d: got %0d want %0d", i, bus.TIME, mstep);
            end
            if (bus.DONE === 1'b1) dones++;
            bus.EXEC  = (i < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.INSTR = 10'($urandom);
            if (mstep == 0) begin
                if (bus.EXEC && !mprev) begin
                    mstep = 1;
                    mop   = bus.INSTR[9:8];
                    starts++;
                end
            end else if ((!mop[1] && mstep == 1) || (mop[1] && mstep == 3)) begin
                mstep = 0;
            end else begin
                mstep++;
            end
            mprev = bus.EXEC;
        end
        n_cmp++;
        if (dones !== starts) begin
            n_fail++;
            $display("FAIL rand_done_count: got %0d want %0d", dones, starts);
        end
    endtask

    initial begin
        bus.EXEC  = 1'b0;
        bus.INSTR = '0;
        test_reset();
        test_load();
        test_add_sub();
        test_mov();
        test_held_exec();
        test_ignore_edge();
        test_reset_held_exec();
        test_reset_mid();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/proc_controller.md
Name: proc_controller

Overview:
- Instruction sequencer for the 10-bit bus processor.
- Latches a 10-bit instruction on an EXEC press and steps a 2-bit timestep counter through T0..T3.
- Drives the bus-source, register-file and ALU control strobes for each timestep.
- Directly upstream of the display stage: supplies TIME (timestep), DONE (instruction complete) and RD_ADDR, which selects the register shown on Q1.

Parameters:
IR_W, 10, instruction width; opcode = IR[IR_W-1:IR_W-2], Rx = IR[IR_W-3:IR_W-4], Ry = IR[IR_W-5:IR_W-6]; remaining bits ignored.

Ports:
CLK  in  1  system clock; all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
EXEC  in  1  start request (level from switch/button, already synchronised); rising edge starts an instruction.
INSTR  in  IR_W  instruction word.
TIME  out  2  current timestep (0=T0 .. 3=T3).
DONE  out  1  high during the final timestep of an instruction.
EXTRN  out  1  bus mux selects external data input.
RD_OE  out  1  register-file Q1 driven onto bus.
RD_ADDR  out  2  register-file read address (Q1).
WR_EN  out  1  register-file write enable (write from bus at next edge).
WR_ADDR  out  2  register-file write address.
A_IN  out  1  ALU operand register A loads from bus.
G_IN  out  1  ALU result register G loads ALU output.
G_OUT  out  1  G driven onto bus.
ALU_SUB  out  1  0 = add, 1 = subtract.

Behaviour:
- Registered state: timestep counter (2 b), instruction register IR (IR_W b), exec_q (previous EXEC).
- All outputs are combinational decodes of counter and IR only; no output depends combinationally on EXEC or INSTR.
- Reset: counter=0, IR=0, exec_q=1, so an EXEC held through reset must be released before it can trigger.
- Outputs after reset: TIME=0, DONE=0, all strobes 0, RD_ADDR=0.
- Start: at T0, if EXEC=1 and exec_q=0, then IR<=INSTR and counter<=1. exec_q<=EXEC every cycle.
- EXEC edges while counter!=0 are ignored, with no queuing. A held EXEC starts exactly one instruction.
- Opcodes and per-timestep outputs (unlisted strobes 0):
  - 00 LOAD: T1: EXTRN, WR_EN, WR_ADDR=Rx, DONE.
  - 01 MOV: T1: RD_ADDR=Ry, RD_OE, WR_EN, WR_ADDR=Rx, DONE.
  - 10 ADD: T1: RD_ADDR=Rx, RD_OE, A_IN. T2: RD_ADDR=Ry, RD_OE, G_IN, ALU_SUB=0. T3: G_OUT, WR_EN, WR_ADDR=Rx, DONE.
  - 11 SUB: same as ADD, except ALU_SUB=1 in T2.
- Counter: increments each cycle while non-zero. In the DONE cycle, counter<=0 (LOAD/MOV: T1 -> T0; ADD/SUB: T3 -> T0).
- Instruction length: LOAD/MOV take 2 cycles (T0 start, T1); ADD/SUB take 4 cycles.
- DONE is high for exactly one cycle per instruction.
- A new instruction may start on the first T0 cycle after DONE.
- At T0 (idle), RD_ADDR=IR Rx so the display shows the last destination register; RD_OE=0.
- Bus exclusivity: at most one of EXTRN, RD_OE, G_OUT is high in any cycle.
- Reset mid-instruction: next cycle returns to reset values. No write strobe may appear in the cycle after RST.
- Fields outside opcode/Rx/Ry have no effect.

Test Plan:
- RST, then INSTR=0b00_10_000000 (LOAD R2), EXEC 0->1: next cycle TIME=1, EXTRN=1, WR_EN=1, WR_ADDR=2, DONE=1; following cycle TIME=0, strobes 0, RD_ADDR=2.
- INSTR=0b10_01_11_0000 (ADD R1,R3), pulse EXEC: T1 RD_ADDR=1/RD_OE/A_IN; T2 RD_ADDR=3/RD_OE/G_IN/ALU_SUB=0; T3 G_OUT/WR_EN/WR_ADDR=1/DONE; then TIME=0.
- SUB (0b11_00_01_0000) -> identical to ADD sequence with ALU_SUB=1 only in T2; MOV R0<-R1 (0b01_00_01_0000) -> single T1 with RD_ADDR=1, WR_ADDR=0, DONE.
- EXEC held high 20 cycles after an ADD start -> exactly one ADD executes. Second rising edge during T2 -> ignored, and INSTR changes mid-instruction do not alter outputs.
- EXEC high across RST deassertion -> no start until EXEC goes 0 then 1. RST asserted at T2 of ADD -> next cycle TIME=0, IR=0, WR_EN never pulses.
- Every cycle of a random instruction stream: assert at most one bus driver active, and DONE count == started instructions.
